tag_read_stage_mp: RTL and testbench

//  Parametrised multi-plane tag-read stage of the reference-pixel cache pipeline; sits between set-input and tag-compare stages.
//  Per accepted cache-line request: forms tag/set address, per-plane (Y,Cb,Cr) cache-line start offsets, destination-block ranges.

---
 rtl/cache_cfg_pkg.sv | 16 +
 rtl/tag_read_plane_geom.sv | 86 ++++++++
 rtl/tag_read_stage_mp.sv | 183 ++++++++++++++++++
 tb/tb_tag_read_stage_mp.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_cfg_pkg.sv
// Shared geometry helpers for the reference-pixel cache pipeline stages:
// per-plane cache-line size derivation and tag width derivation.
package cache_cfg_pkg;

  // Plane 0 is luma; every other plane is a subsampled chroma plane.
  function automatic int plane_cl_size(input int plane, input int luma_size, input int sub);
    return (plane == 0) ? luma_size : luma_size - sub;
  endfunction

  function automatic int tag_wdth(input int ref_w, input int x_w, input int y_w,
                                  input int cl_h, input int cl_v,
                                  input int set_x, input int set_y);
    return ref_w + (x_w - cl_h - set_x) + (y_w - cl_v - set_y);
  endfunction

endpackage

// File: rtl/tag_read_plane_geom.sv
// One plane's cache-line start offsets and destination-block ranges,
// plus the running range registers that carry geometry across lines.
module tag_read_plane_geom #(
  parameter int CLH     = 3,
  parameter int CLV     = 3,
  parameter int OUT_CLH = 3,
  parameter int OUT_CLV = 3,
  parameter int DIM_W   = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             accept,
  input  logic             xy_changed,
  input  logic [1:0]       curr_x,
  input  logic [1:0]       curr_y,
  input  logic [1:0]       delta_x,
  input  logic [1:0]       delta_y,
  input  logic [CLH-1:0]   start_x_low,
  input  logic [CLV-1:0]   start_y_low,
  input  logic [DIM_W-1:0] off_x,
  input  logic [DIM_W-1:0] off_y,
  input  logic [DIM_W-1:0] blk_w,
  input  logic [DIM_W-1:0] blk_h,
  output logic [OUT_CLH-1:0] cl_strt_x,
  output logic [OUT_CLV-1:0] cl_strt_y,
  output logic [DIM_W-1:0] dst_strt_x,
  output logic [DIM_W-1:0] dst_end_x,
  output logic [DIM_W-1:0] dst_strt_y,
  output logic [DIM_W-1:0] dst_end_y
);

  localparam logic [DIM_W-1:0] LINE_W = DIM_W'(1 << CLH);
  localparam logic [DIM_W-1:0] LINE_H = DIM_W'(1 << CLV);
  localparam logic [DIM_W-1:0] ONE    = DIM_W'(1);

  logic [DIM_W-1:0] run_strt_x, run_end_x, run_strt_y, run_end_y;
  logic [DIM_W-1:0] first_end_x, first_end_y;
  logic             x_first, y_first, x_final, y_final;

  assign x_first = (curr_x == 2'd0);
  assign y_first = (curr_y == 2'd0);
  assign x_final = (curr_x == delta_x);
  assign y_final = (curr_y == delta_y);

  // First line of a block only covers the samples from the block start to the line end.
  assign first_end_x = (LINE_W - ONE) - DIM_W'(start_x_low) + off_x;
  assign first_end_y = (LINE_H - ONE) - DIM_W'(start_y_low) + off_y;

  always_comb begin
    cl_strt_x  = x_first ? OUT_CLH'(start_x_low) : '0;
    cl_strt_y  = y_first ? OUT_CLV'(start_y_low) : '0;
    dst_strt_x = run_strt_x;
    dst_end_x  = run_end_x;
    dst_strt_y = run_strt_y;
    dst_end_y  = run_end_y;
    if (xy_changed) begin
      dst_strt_x = x_first ? off_x : run_end_x + ONE;
      if (x_final)      dst_end_x = off_x + blk_w;
      else if (x_first) dst_end_x = first_end_x;
      else              dst_end_x = run_end_x + LINE_W;
      // y advances only on the first line of a row; inside a row it is held.
      if (y_first) begin
        dst_strt_y = off_y;
        dst_end_y  = y_final ? off_y + blk_h : first_end_y;
      end else if (x_first) begin
        dst_strt_y = run_end_y + ONE;
        dst_end_y  = y_final ? off_y + blk_h : run_end_y + LINE_H;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_strt_x <= '0;
      run_end_x  <= '0;
      run_strt_y <= '0;
      run_end_y  <= '0;
    end else if (accept && xy_changed) begin
      run_strt_x <= dst_strt_x;
      run_end_x  <= dst_end_x;
      run_strt_y <= dst_strt_y;
      run_end_y  <= dst_end_y;
    end
  end

endmodule

// File: rtl/tag_read_stage_mp.sv
// Multi-plane tag-read stage: tag/set address and per-plane geometry per line,
// registered output with a one-entry skid. TAG_READ_PERF_CNT_EN adds perf counters.
module tag_read_stage_mp
  import cache_cfg_pkg::*;
#(
  parameter int NUM_PLANES    = 3,
  parameter int X_ADDR_WDTH   = 12,
  parameter int Y_ADDR_WDTH   = 12,
  parameter int CL_H_SIZE     = 3,
  parameter int CL_V_SIZE     = 3,
  parameter int C_SUB_W       = 1,
  parameter int C_SUB_H       = 1,
  parameter int SET_X_WDTH    = 2,
  parameter int SET_Y_WDTH    = 2,
  parameter int REF_ADDR_WDTH = 4,
  parameter int DIM_WDTH      = 7,
  localparam int XL_WDTH  = X_ADDR_WDTH - CL_H_SIZE,
  localparam int YL_WDTH  = Y_ADDR_WDTH - CL_V_SIZE,
  localparam int TAG_WDTH = tag_wdth(REF_ADDR_WDTH, X_ADDR_WDTH, Y_ADDR_WDTH,
                                     CL_H_SIZE, CL_V_SIZE, SET_X_WDTH, SET_Y_WDTH)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_last,
  input  logic [REF_ADDR_WDTH-1:0]          ref_idx,
  input  logic [XL_WDTH-1:0]                curr_x_addr,
  input  logic [YL_WDTH-1:0]                curr_y_addr,
  input  logic [2*NUM_PLANES-1:0]           pl_curr_x,
  input  logic [2*NUM_PLANES-1:0]           pl_curr_y,
  input  logic [2*NUM_PLANES-1:0]           pl_delta_x,
  input  logic [2*NUM_PLANES-1:0]           pl_delta_y,
  input  logic [NUM_PLANES-1:0]             pl_xy_changed,
  input  logic [X_ADDR_WDTH*NUM_PLANES-1:0] pl_start_x,
  input  logic [Y_ADDR_WDTH*NUM_PLANES-1:0] pl_start_y,
  input  logic [DIM_WDTH*NUM_PLANES-1:0]    pl_off_x,
  input  logic [DIM_WDTH*NUM_PLANES-1:0]    pl_off_y,
  input  logic [DIM_WDTH*NUM_PLANES-1:0]    pl_blk_w,
  input  logic [DIM_WDTH*NUM_PLANES-1:0]    pl_blk_h,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic [REF_ADDR_WDTH-1:0]          ref_idx_d,
  output logic [SET_Y_WDTH+SET_X_WDTH-1:0]  set_addr,
  output logic [TAG_WDTH-1:0]               tag_addr,
  output logic [CL_H_SIZE*NUM_PLANES-1:0]   pl_cl_strt_x,
  output logic [CL_V_SIZE*NUM_PLANES-1:0]   pl_cl_strt_y,
  output logic [DIM_WDTH*NUM_PLANES-1:0]    pl_dst_strt_x,
  output logic [DIM_WDTH*NUM_PLANES-1:0]    pl_dst_strt_y,
  output logic [DIM_WDTH*NUM_PLANES-1:0]    pl_dst_end_x,
  output logic [DIM_WDTH*NUM_PLANES-1:0]    pl_dst_end_y
`ifdef TAG_READ_PERF_CNT_EN
  ,
  output logic [31:0]                       perf_beats,
  output logic [31:0]                       perf_stall
`endif
);

  localparam int PD = DIM_WDTH * NUM_PLANES;

  typedef struct packed {
    logic                             last;
    logic [REF_ADDR_WDTH-1:0]         ref_idx;
    logic [SET_Y_WDTH+SET_X_WDTH-1:0] set_addr;
    logic [TAG_WDTH-1:0]              tag_addr;
    logic [CL_H_SIZE*NUM_PLANES-1:0]  cl_x;
    logic [CL_V_SIZE*NUM_PLANES-1:0]  cl_y;
    logic [PD-1:0]                    ds_x;
    logic [PD-1:0]                    de_x;
    logic [PD-1:0]                    ds_y;
    logic [PD-1:0]                    de_y;
  } beat_t;

  beat_t nxt_beat, out_q, skid_q;
  logic  out_valid_q, skid_valid_q, accept;
  logic [CL_H_SIZE*NUM_PLANES-1:0] nxt_cl_x;
  logic [CL_V_SIZE*NUM_PLANES-1:0] nxt_cl_y;
  logic [PD-1:0] nxt_ds_x, nxt_de_x, nxt_ds_y, nxt_de_y;
  logic unused_start_bits;

  // Only the in-line offset bits of each plane start coordinate matter here.
  assign unused_start_bits = ^{pl_start_x, pl_start_y};

  // Handshake: a beat moves when valid && ready in the same cycle. in_ready is
  // the registered "skid empty" flag, so it never depends on out_ready
  // combinationally; out_* are held stable while out_valid && !out_ready.
  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;

  for (genvar p = 0; p < NUM_PLANES; p++) begin : g_plane
    localparam int PCLH = plane_cl_size(p, CL_H_SIZE, C_SUB_W);
    localparam int PCLV = plane_cl_size(p, CL_V_SIZE, C_SUB_H);
    tag_read_plane_geom #(
      .CLH(PCLH), .CLV(PCLV), .OUT_CLH(CL_H_SIZE), .OUT_CLV(CL_V_SIZE), .DIM_W(DIM_WDTH)
    ) u_geom (
      .clk         (clk),
      .reset       (reset),
      .accept      (accept),
      .xy_changed  (pl_xy_changed[p]),
      .curr_x      (pl_curr_x[2*p +: 2]),
      .curr_y      (pl_curr_y[2*p +: 2]),
      .delta_x     (pl_delta_x[2*p +: 2]),
      .delta_y     (pl_delta_y[2*p +: 2]),
      .start_x_low (pl_start_x[p*X_ADDR_WDTH +: PCLH]),
      .start_y_low (pl_start_y[p*Y_ADDR_WDTH +: PCLV]),
      .off_x       (pl_off_x[p*DIM_WDTH +: DIM_WDTH]),
      .off_y       (pl_off_y[p*DIM_WDTH +: DIM_WDTH]),
      .blk_w       (pl_blk_w[p*DIM_WDTH +: DIM_WDTH]),
      .blk_h       (pl_blk_h[p*DIM_WDTH +: DIM_WDTH]),
      .cl_strt_x   (nxt_cl_x[p*CL_H_SIZE +: CL_H_SIZE]),
      .cl_strt_y   (nxt_cl_y[p*CL_V_SIZE +: CL_V_SIZE]),
      .dst_strt_x  (nxt_ds_x[p*DIM_WDTH +: DIM_WDTH]),
      .dst_end_x   (nxt_de_x[p*DIM_WDTH +: DIM_WDTH]),
      .dst_strt_y  (nxt_ds_y[p*DIM_WDTH +: DIM_WDTH]),
      .dst_end_y   (nxt_de_y[p*DIM_WDTH +: DIM_WDTH])
    );
  end

  always_comb begin
    nxt_beat          = '0;
    nxt_beat.last     = in_last;
    nxt_beat.ref_idx  = ref_idx;
    nxt_beat.set_addr = {curr_y_addr[SET_Y_WDTH-1:0], curr_x_addr[SET_X_WDTH-1:0]};
    nxt_beat.tag_addr = {ref_idx, curr_y_addr[YL_WDTH-1:SET_Y_WDTH],
                         curr_x_addr[XL_WDTH-1:SET_X_WDTH]};
    nxt_beat.cl_x     = nxt_cl_x;
    nxt_beat.cl_y     = nxt_cl_y;
    nxt_beat.ds_x     = nxt_ds_x;
    nxt_beat.de_x     = nxt_de_x;
    nxt_beat.ds_y     = nxt_ds_y;
    nxt_beat.de_y     = nxt_de_y;
  end

  // The skid only fills while the output is stalled, so it always drains first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_q       <= nxt_beat;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q       <= nxt_beat;
      skid_valid_q <= 1'b1;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_last      = out_q.last;
  assign ref_idx_d     = out_q.ref_idx;
  assign set_addr      = out_q.set_addr;
  assign tag_addr      = out_q.tag_addr;
  assign pl_cl_strt_x  = out_q.cl_x;
  assign pl_cl_strt_y  = out_q.cl_y;
  assign pl_dst_strt_x = out_q.ds_x;
  assign pl_dst_end_x  = out_q.de_x;
  assign pl_dst_strt_y = out_q.ds_y;
  assign pl_dst_end_y  = out_q.de_y;

`ifdef TAG_READ_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_beats <= '0;
      perf_stall <= '0;
    end else begin
      if (out_valid_q && out_ready && perf_beats != '1) perf_beats <= perf_beats + 32'd1;
      if (out_valid_q && !out_ready && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tag_read_stage_mp.sv
// Directed bench for tag_read_stage_mp: stimulus pushes hand-computed expected
// luma-plane beats; a negedge monitor pops and compares on each output handshake.
module tb_tag_read_stage_mp;

  typedef struct packed {
    logic        last;
    logic [3:0]  ref_idx;
    logic [3:0]  set;
    logic [17:0] tag;
    logic [2:0]  clx;
    logic [2:0]  cly;
    logic [6:0]  dsx;
    logic [6:0]  dex;
    logic [6:0]  dsy;
    logic [6:0]  dey;
    logic        rest;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [3:0]  ref_idx = '0;
  logic [8:0]  curr_x_addr = '0, curr_y_addr = '0;
  logic [5:0]  pl_curr_x = '0, pl_curr_y = '0, pl_delta_x = '0, pl_delta_y = '0;
  logic [2:0]  pl_xy_changed = '0;
  logic [35:0] pl_start_x = '0, pl_start_y = '0;
  logic [20:0] pl_off_x = '0, pl_off_y = '0, pl_blk_w = '0, pl_blk_h = '0;
  logic        out_valid, out_ready = 1'b1, out_last;
  logic [3:0]  ref_idx_d, set_addr;
  logic [17:0] tag_addr;
  logic [8:0]  pl_cl_strt_x, pl_cl_strt_y;
  logic [20:0] pl_dst_strt_x, pl_dst_strt_y, pl_dst_end_x, pl_dst_end_y;
`ifdef TAG_READ_PERF_CNT_EN
  logic [31:0] perf_beats, perf_stall;
`endif

  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  exp_t mon_act;
  logic [EXP_W-1:0] mon_exp;

  tag_read_stage_mp dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .ref_idx(ref_idx), .curr_x_addr(curr_x_addr), .curr_y_addr(curr_y_addr),
    .pl_curr_x(pl_curr_x), .pl_curr_y(pl_curr_y), .pl_delta_x(pl_delta_x),
    .pl_delta_y(pl_delta_y), .pl_xy_changed(pl_xy_changed),
    .pl_start_x(pl_start_x), .pl_start_y(pl_start_y), .pl_off_x(pl_off_x),
    .pl_off_y(pl_off_y), .pl_blk_w(pl_blk_w), .pl_blk_h(pl_blk_h),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .ref_idx_d(ref_idx_d), .set_addr(set_addr), .tag_addr(tag_addr),
    .pl_cl_strt_x(pl_cl_strt_x), .pl_cl_strt_y(pl_cl_strt_y),
    .pl_dst_strt_x(pl_dst_strt_x), .pl_dst_strt_y(pl_dst_strt_y),
    .pl_dst_end_x(pl_dst_end_x), .pl_dst_end_y(pl_dst_end_y)
`ifdef TAG_READ_PERF_CNT_EN
    , .perf_beats(perf_beats), .perf_stall(perf_stall)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic last, input logic [3:0] r, input logic [3:0] s,
                              input logic [17:0] t, input logic [2:0] clx, input logic [2:0] cly,
                              input logic [6:0] dsx, input logic [6:0] dex,
                              input logic [6:0] dsy, input logic [6:0] dey);
    exp_t e;
    e.last = last; e.ref_idx = r; e.set = s; e.tag = t; e.clx = clx; e.cly = cly;
    e.dsx = dsx; e.dex = dex; e.dsy = dsy; e.dey = dey; e.rest = 1'b0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, want);
    end
  endtask

  // driver: present one luma beat (other planes idle) and record its expectation at accept
  task automatic send_beat(input logic [3:0] r, input logic [8:0] xa, input logic [8:0] ya,
                           input logic [1:0] cx, input logic [1:0] dx,
                           input logic [1:0] cy, input logic [1:0] dy, input logic ch,
                           input logic [11:0] sx, input logic [11:0] sy,
                           input logic [6:0] ox, input logic [6:0] oy,
                           input logic [6:0] bw, input logic [6:0] bh,
                           input logic last, input exp_t e);
    int t;
    ref_idx = r; curr_x_addr = xa; curr_y_addr = ya;
    pl_curr_x = {4'b0, cx}; pl_delta_x = {4'b0, dx};
    pl_curr_y = {4'b0, cy}; pl_delta_y = {4'b0, dy};
    pl_xy_changed = {2'b11, ch};
    pl_start_x = {24'b0, sx}; pl_start_y = {24'b0, sy};
    pl_off_x = {14'b0, ox}; pl_off_y = {14'b0, oy};
    pl_blk_w = {14'b0, bw}; pl_blk_h = {14'b0, bh};
    in_last = last;
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout ref=%0d in_ready=%0b", r, in_ready);
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      mon_act.last = out_last; mon_act.ref_idx = ref_idx_d; mon_act.set = set_addr;
      mon_act.tag = tag_addr; mon_act.clx = pl_cl_strt_x[2:0]; mon_act.cly = pl_cl_strt_y[2:0];
      mon_act.dsx = pl_dst_strt_x[6:0]; mon_act.dex = pl_dst_end_x[6:0];
      mon_act.dsy = pl_dst_strt_y[6:0]; mon_act.dey = pl_dst_end_y[6:0];
      mon_act.rest = |{pl_cl_strt_x[8:3], pl_cl_strt_y[8:3], pl_dst_strt_x[20:7],
                       pl_dst_end_x[20:7], pl_dst_strt_y[20:7], pl_dst_end_y[20:7]};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected got=%h", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL beat got=%h exp=%h", mon_act, mon_exp);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_tag", 32'(tag_addr), 32'd0);
    chk("rst_dst_end_x", pl_dst_end_x[20:0], 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // single-line block
    send_beat(4'd1, 9'd0, 9'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 12'd3, 12'd0, 7'd0, 7'd0, 7'd4, 7'd0, 1'b1,
              mk(1'b1, 4'd1, 4'd0, {4'd1, 14'd0}, 3'd3, 3'd0, 7'd0, 7'd4, 7'd0, 7'd0));
    // two lines wide
    send_beat(4'd2, 9'd0, 9'd0, 2'd0, 2'd1, 2'd0, 2'd0, 1'b1, 12'd5, 12'd0, 7'd0, 7'd0, 7'd9, 7'd2, 1'b0,
              mk(1'b0, 4'd2, 4'd0, {4'd2, 14'd0}, 3'd5, 3'd0, 7'd0, 7'd2, 7'd0, 7'd2));
    send_beat(4'd3, 9'd0, 9'd0, 2'd1, 2'd1, 2'd0, 2'd0, 1'b1, 12'd5, 12'd0, 7'd0, 7'd0, 7'd9, 7'd2, 1'b1,
              mk(1'b1, 4'd3, 4'd0, {4'd3, 14'd0}, 3'd0, 3'd0, 7'd3, 7'd9, 7'd0, 7'd2));
    // three lines wide, one repeated beat without geometry advance
    send_beat(4'd4, 9'd0, 9'd0, 2'd0, 2'd2, 2'd0, 2'd0, 1'b1, 12'd6, 12'd0, 7'd0, 7'd0, 7'd17, 7'd0, 1'b0,
              mk(1'b0, 4'd4, 4'd0, {4'd4, 14'd0}, 3'd6, 3'd0, 7'd0, 7'd1, 7'd0, 7'd0));
    send_beat(4'd5, 9'd0, 9'd0, 2'd1, 2'd2, 2'd0, 2'd0, 1'b0, 12'd6, 12'd0, 7'd0, 7'd0, 7'd17, 7'd0, 1'b0,
              mk(1'b0, 4'd5, 4'd0, {4'd5, 14'd0}, 3'd0, 3'd0, 7'd0, 7'd1, 7'd0, 7'd0));
    send_beat(4'd6, 9'd0, 9'd0, 2'd1, 2'd2, 2'd0, 2'd0, 1'b1, 12'd6, 12'd0, 7'd0, 7'd0, 7'd17, 7'd0, 1'b0,
              mk(1'b0, 4'd6, 4'd0, {4'd6, 14'd0}, 3'd0, 3'd0, 7'd2, 7'd9, 7'd0, 7'd0));
    send_beat(4'd7, 9'd0, 9'd0, 2'd2, 2'd2, 2'd0, 2'd0, 1'b1, 12'd6, 12'd0, 7'd0, 7'd0, 7'd17, 7'd0, 1'b1,
              mk(1'b1, 4'd7, 4'd0, {4'd7, 14'd0}, 3'd0, 3'd0, 7'd10, 7'd17, 7'd0, 7'd0));
    // address formation
    send_beat(4'd5, 9'h0B6, 9'h05D, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 12'd0, 12'd0, 7'd0, 7'd0, 7'd0, 7'd0, 1'b1,
              mk(1'b1, 4'd5, 4'h6, {4'h5, 7'h17, 7'h2D}, 3'd0, 3'd0, 7'd0, 7'd0, 7'd0, 7'd0));
    // 2x2 lines with offsets; upper start bits must be ignored
    send_beat(4'd8, 9'd0, 9'd0, 2'd0, 2'd1, 2'd0, 2'd1, 1'b1, 12'h0AD, 12'h0F6, 7'd10, 7'd20, 7'd9, 7'd9, 1'b0,
              mk(1'b0, 4'd8, 4'd0, {4'd8, 14'd0}, 3'd5, 3'd6, 7'd10, 7'd12, 7'd20, 7'd21));
    send_beat(4'd9, 9'd0, 9'd0, 2'd1, 2'd1, 2'd0, 2'd1, 1'b1, 12'h0AD, 12'h0F6, 7'd10, 7'd20, 7'd9, 7'd9, 1'b0,
              mk(1'b0, 4'd9, 4'd0, {4'd9, 14'd0}, 3'd0, 3'd6, 7'd13, 7'd19, 7'd20, 7'd21));
    send_beat(4'd10, 9'd0, 9'd0, 2'd0, 2'd1, 2'd1, 2'd1, 1'b1, 12'h0AD, 12'h0F6, 7'd10, 7'd20, 7'd9, 7'd9, 1'b0,
              mk(1'b0, 4'd10, 4'd0, {4'd10, 14'd0}, 3'd5, 3'd0, 7'd10, 7'd12, 7'd22, 7'd29));
    send_beat(4'd11, 9'd0, 9'd0, 2'd1, 2'd1, 2'd1, 2'd1, 1'b1, 12'h0AD, 12'h0F6, 7'd10, 7'd20, 7'd9, 7'd9, 1'b1,
              mk(1'b1, 4'd11, 4'd0, {4'd11, 14'd0}, 3'd0, 3'd0, 7'd13, 7'd19, 7'd22, 7'd29));
    // range arithmetic wraps modulo 128
    send_beat(4'd9, 9'd0, 9'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 12'd0, 12'd0, 7'd120, 7'd0, 7'd15, 7'd0, 1'b1,
              mk(1'b1, 4'd9, 4'd0, {4'd9, 14'd0}, 3'd0, 3'd0, 7'd120, 7'd7, 7'd0, 7'd0));
    wait_drain();

    // output stall: output reg and skid fill, then in_ready drops
    out_ready = 1'b0;
    fork
      begin
        send_beat(4'd10, 9'd0, 9'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 12'd0, 12'd0, 7'd0, 7'd0, 7'd1, 7'd0, 1'b0,
                  mk(1'b0, 4'd10, 4'd0, {4'd10, 14'd0}, 3'd0, 3'd0, 7'd0, 7'd1, 7'd0, 7'd0));
        send_beat(4'd11, 9'd0, 9'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 12'd0, 12'd0, 7'd0, 7'd0, 7'd2, 7'd0, 1'b0,
                  mk(1'b0, 4'd11, 4'd0, {4'd11, 14'd0}, 3'd0, 3'd0, 7'd0, 7'd2, 7'd0, 7'd0));
        send_beat(4'd12, 9'd0, 9'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 12'd0, 12'd0, 7'd0, 7'd0, 7'd3, 7'd0, 1'b1,
                  mk(1'b1, 4'd12, 4'd0, {4'd12, 14'd0}, 3'd0, 3'd0, 7'd0, 7'd3, 7'd0, 7'd0));
      end
      begin
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // reset mid-burst discards in-flight beats and running state
    out_ready = 1'b0;
    send_beat(4'd6, 9'd0, 9'd0, 2'd0, 2'd1, 2'd0, 2'd0, 1'b1, 12'd5, 12'd0, 7'd0, 7'd0, 7'd9, 7'd0, 1'b0,
              mk(1'b0, 4'd6, 4'd0, {4'd6, 14'd0}, 3'd5, 3'd0, 7'd0, 7'd2, 7'd0, 7'd0));
    send_beat(4'd7, 9'd0, 9'd0, 2'd1, 2'd1, 2'd0, 2'd0, 1'b1, 12'd5, 12'd0, 7'd0, 7'd0, 7'd9, 7'd0, 1'b1,
              mk(1'b1, 4'd7, 4'd0, {4'd7, 14'd0}, 3'd0, 3'd0, 7'd3, 7'd9, 7'd0, 7'd0));
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_tag", 32'(tag_addr), 32'd0);
    chk("mid_rst_dst_end_x", pl_dst_end_x[20:0], 32'd0);
    chk("mid_rst_cl_x", 32'(pl_cl_strt_x), 32'd0);
`ifdef TAG_READ_PERF_CNT_EN
    chk("mid_rst_perf_beats", perf_beats, 32'd0);
    chk("mid_rst_perf_stall", perf_stall, 32'd0);
`endif
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    send_beat(4'd8, 9'd0, 9'd0, 2'd1, 2'd1, 2'd0, 2'd0, 1'b1, 12'd5, 12'd0, 7'd0, 7'd0, 7'd9, 7'd0, 1'b1,
              mk(1'b1, 4'd8, 4'd0, {4'd8, 14'd0}, 3'd0, 3'd0, 7'd1, 7'd9, 7'd0, 7'd0));
    wait_drain();
    chk("drain", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
